// File: rtl/branch_predict_unit.sv
// Branch resolution (signed compares) plus a 2-bit saturating-counter PHT for IF
// prediction, misprediction flagging and saturating branch statistics.
module branch_predict_unit #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [2:0]        ex_branch_type,
  input  logic [DATA_W-1:0] ex_op1,
  input  logic [DATA_W-1:0] ex_op2,
  input  logic              ex_pred_taken,
  output logic              ex_taken,
  output logic              ex_is_branch,
  output logic              ex_mispredict,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  mispredict_count
);

  localparam int PHT_N = 2 ** IDX_W;
  localparam logic [2:0] T_BEQ  = 3'b001;
  localparam logic [2:0] T_BNE  = 3'b010;
  localparam logic [2:0] T_BLEZ = 3'b011;
  localparam logic [2:0] T_BGTZ = 3'b100;
  localparam logic [2:0] T_BLTZ = 3'b101;
  localparam logic [2:0] T_BGEZ = 3'b110;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       pht [PHT_N];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       ex_ctr;
  logic [1:0]       ex_ctr_next;
  logic             cond;
  logic             unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                            ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

  always_comb begin
    cond = 1'b0;
    case (ex_branch_type)
      T_BEQ:   cond = (ex_op1 == ex_op2);
      T_BNE:   cond = (ex_op1 != ex_op2);
      T_BLEZ:  cond = ($signed(ex_op1) <= $signed(ex_op2));
      T_BGTZ:  cond = ($signed(ex_op1) >  $signed(ex_op2));
      T_BLTZ:  cond = ($signed(ex_op1) <  $signed(ex_op2));
      T_BGEZ:  cond = ($signed(ex_op1) >= $signed(ex_op2));
      default: cond = 1'b0;
    endcase
  end

  assign ex_is_branch  = ex_valid && (ex_branch_type != 3'b000) && (ex_branch_type != 3'b111);
  assign ex_taken      = ex_is_branch && cond;
  assign ex_mispredict = ex_is_branch && (ex_taken != ex_pred_taken);

  // Reads see the pre-update table; a write lands at the edge.
  assign if_pred_taken = pht[if_idx][1];
  assign ex_ctr        = pht[ex_idx];

  always_comb begin
    ex_ctr_next = ex_ctr;
    if (ex_taken) begin
      if (ex_ctr != 2'b11) ex_ctr_next = ex_ctr + 2'd1;
    end else begin
      if (ex_ctr != 2'b00) ex_ctr_next = ex_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
    end else if (ex_is_branch) begin
      pht[ex_idx] <= ex_ctr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (ex_is_branch && (branch_count != '1))
        branch_count <= branch_count + CNT_ONE;
      if (ex_mispredict && (mispredict_count != '1))
        mispredict_count <= mispredict_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench: stimulus queues expected values tagged with a cycle; a
// negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predict_unit;

  localparam logic [2:0] BEQ  = 3'b001;
  localparam logic [2:0] BNE  = 3'b010;
  localparam logic [2:0] BLEZ = 3'b011;
  localparam logic [2:0] BGTZ = 3'b100;
  localparam logic [2:0] BLTZ = 3'b101;
  localparam logic [2:0] BGEZ = 3'b110;
  localparam logic [2:0] RSVD = 3'b111;

  localparam int S_PRED = 0, S_TAKEN = 1, S_ISBR = 2, S_MISP = 3;
  localparam int S_BCNT = 4, S_MCNT = 5, S_SBCNT = 6, S_SMCNT = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reset_small = 1'b0;
  logic [31:0] if_pc = '0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [2:0]  ex_branch_type = '0;
  logic [31:0] ex_op1 = '0;
  logic [31:0] ex_op2 = '0;
  logic        ex_pred_taken = 1'b0;

  logic        if_pred_taken, ex_taken, ex_is_branch, ex_mispredict;
  logic [15:0] branch_count, mispredict_count;
  logic        s_pred, s_taken, s_isbr, s_misp;
  logic [1:0]  s_bcnt, s_mcnt;

  branch_predict_unit dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch_type(ex_branch_type),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_pred_taken(ex_pred_taken),
    .ex_taken(ex_taken), .ex_is_branch(ex_is_branch), .ex_mispredict(ex_mispredict),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_predict_unit #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset_small), .if_pc(if_pc), .if_pred_taken(s_pred),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch_type(ex_branch_type),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_pred_taken(ex_pred_taken),
    .ex_taken(s_taken), .ex_is_branch(s_isbr), .ex_mispredict(s_misp),
    .branch_count(s_bcnt), .mispredict_count(s_mcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cycle;
    string       name;
    int          sig;
    logic [31:0] value;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(int sig);
    case (sig)
      S_PRED:  return {31'b0, if_pred_taken};
      S_TAKEN: return {31'b0, ex_taken};
      S_ISBR:  return {31'b0, ex_is_branch};
      S_MISP:  return {31'b0, ex_mispredict};
      S_BCNT:  return {16'b0, branch_count};
      S_MCNT:  return {16'b0, mispredict_count};
      S_SBCNT: return {30'b0, s_bcnt};
      default: return {30'b0, s_mcnt};
    endcase
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [31:0] actual;
    actual = sample(e.sig);
    checks++;
    if (e.cycle != cyc)
      $display("[TB] FAIL %s: expectation for cycle %0d reached at cycle %0d", e.name, e.cycle, cyc);
    else if (actual !== e.value)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", e.name, actual, e.value, cyc);
    else
      passes++;
  endtask

  // Monitor: compare every expectation that falls due in the current cycle.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cycle <= cyc) begin
        checkOutput(sb_q[i]);
        sb_q.delete(i);
      end
    end
  end

  task automatic push(input string name, input int sig, input logic [31:0] value, input int delay);
    exp_t e;
    e.cycle = cyc + delay;
    e.name  = name;
    e.sig   = sig;
    e.value = value;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] btype,
                               input logic [31:0] op1, input logic [31:0] op2,
                               input logic [31:0] pc, input logic pred,
                               input logic [31:0] ipc);
    ex_valid       = valid;
    ex_branch_type = btype;
    ex_op1         = op1;
    ex_op2         = op2;
    ex_pc          = pc;
    ex_pred_taken  = pred;
    if_pc          = ipc;
  endtask

  task automatic idle(input logic [31:0] ipc);
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, ipc);
  endtask

  task automatic reset_dut();
    step();
    idle(32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int wait_cycles;
    reset_small = 1'b1;
    reset_dut();
    reset_small = 1'b0;

    // Post-reset sweep: every entry is weak-NT.
    for (int i = 0; i < 16; i++) begin
      step();
      idle(32'(i * 4));
      push("sweep_pred", S_PRED, 32'd0, 0);
      if (i == 0) begin
        push("reset_bcnt", S_BCNT, 32'd0, 0);
        push("reset_mcnt", S_MCNT, 32'd0, 0);
      end
    end

    // Signed compares at 0x44.
    reset_dut();
    step(); applyStimulus(1'b1, BLTZ, 32'hFFFF_FFFF, 32'h0, 32'h44, 1'b0, 32'h0);
    push("bltz_neg_taken", S_TAKEN, 32'd1, 0); push("bltz_misp", S_MISP, 32'd1, 0);
    step(); applyStimulus(1'b1, BGTZ, 32'hFFFF_FFFF, 32'h0, 32'h44, 1'b0, 32'h0);
    push("bgtz_neg_taken", S_TAKEN, 32'd0, 0); push("bgtz_misp", S_MISP, 32'd0, 0);
    step(); applyStimulus(1'b1, BGEZ, 32'h0, 32'h0, 32'h44, 1'b0, 32'h0);
    push("bgez_zero_taken", S_TAKEN, 32'd1, 0);
    step(); applyStimulus(1'b1, BLEZ, 32'h7FFF_FFFF, 32'h0, 32'h44, 1'b0, 32'h0);
    push("blez_max_taken", S_TAKEN, 32'd0, 0);
    push("signed_bcnt", S_BCNT, 32'd4, 1); push("signed_mcnt", S_MCNT, 32'd2, 1);
    step(); idle(32'h44);
    push("signed_pred_44", S_PRED, 32'd0, 0);

    // Saturation at 0x40: 4 taken then 3 not-taken.
    reset_dut();
    step(); applyStimulus(1'b1, BEQ, 32'd7, 32'd7, 32'h40, 1'b0, 32'h40);
    push("sat_t0_pred", S_PRED, 32'd0, 0);
    step(); applyStimulus(1'b1, BEQ, 32'd7, 32'd7, 32'h40, 1'b0, 32'h40);
    push("sat_t1_pred", S_PRED, 32'd1, 0);
    step(); applyStimulus(1'b1, BEQ, 32'd7, 32'd7, 32'h40, 1'b0, 32'h40);
    push("sat_t2_pred", S_PRED, 32'd1, 0);
    step(); applyStimulus(1'b1, BEQ, 32'd7, 32'd7, 32'h40, 1'b0, 32'h40);
    push("sat_t3_pred", S_PRED, 32'd1, 0);
    step(); applyStimulus(1'b1, BEQ, 32'd1, 32'd2, 32'h40, 1'b0, 32'h40);
    push("sat_n0_pred", S_PRED, 32'd1, 0);
    step(); applyStimulus(1'b1, BEQ, 32'd1, 32'd2, 32'h40, 1'b0, 32'h40);
    push("sat_n1_pred", S_PRED, 32'd1, 0);
    step(); applyStimulus(1'b1, BEQ, 32'd1, 32'd2, 32'h40, 1'b0, 32'h40);
    push("sat_n2_pred", S_PRED, 32'd0, 0);
    push("sat_bcnt", S_BCNT, 32'd7, 1); push("sat_mcnt", S_MCNT, 32'd4, 1);
    step(); applyStimulus(1'b1, BEQ, 32'd7, 32'd7, 32'h40, 1'b1, 32'h40);
    push("sat_n3_pred", S_PRED, 32'd0, 0);
    step(); idle(32'h40);
    push("sat_floor_pred", S_PRED, 32'd0, 0);

    // Mispredict and qualifiers.
    reset_dut();
    step(); applyStimulus(1'b1, BNE, 32'd5, 32'd5, 32'h48, 1'b1, 32'h0);
    push("misp_flag", S_MISP, 32'd1, 0); push("misp_taken", S_TAKEN, 32'd0, 0);
    push("misp_isbr", S_ISBR, 32'd1, 0); push("misp_mcnt_before", S_MCNT, 32'd0, 0);
    push("misp_mcnt_after", S_MCNT, 32'd1, 1); push("misp_bcnt_after", S_BCNT, 32'd1, 1);
    step(); applyStimulus(1'b0, BEQ, 32'd3, 32'd3, 32'h4C, 1'b0, 32'h4C);
    push("novalid_taken", S_TAKEN, 32'd0, 0); push("novalid_isbr", S_ISBR, 32'd0, 0);
    push("novalid_misp", S_MISP, 32'd0, 0);
    step(); applyStimulus(1'b1, RSVD, 32'd3, 32'd3, 32'h4C, 1'b0, 32'h4C);
    push("rsvd_taken", S_TAKEN, 32'd0, 0); push("rsvd_isbr", S_ISBR, 32'd0, 0);
    step(); applyStimulus(1'b1, RSVD, 32'd3, 32'd3, 32'h4C, 1'b0, 32'h4C);
    push("qual_pred_4c", S_PRED, 32'd0, 0);
    push("qual_bcnt", S_BCNT, 32'd1, 0); push("qual_mcnt", S_MCNT, 32'd1, 0);

    // Same-cycle read/write at 0x80, then reset colliding with an update.
    reset_dut();
    step(); applyStimulus(1'b1, BEQ, 32'd9, 32'd9, 32'h80, 1'b1, 32'h80);
    push("rw_same_cycle_pred", S_PRED, 32'd0, 0);
    step(); idle(32'h80);
    push("rw_next_cycle_pred", S_PRED, 32'd1, 0);
    reset_dut();
    step(); applyStimulus(1'b1, BEQ, 32'd9, 32'd9, 32'h80, 1'b0, 32'h80);
    reset = 1'b1;
    push("rst_cycle_taken", S_TAKEN, 32'd1, 0);
    step(); idle(32'h80); reset = 1'b0;
    push("rst_prio_pred", S_PRED, 32'd0, 0);
    push("rst_prio_bcnt", S_BCNT, 32'd0, 0); push("rst_prio_mcnt", S_MCNT, 32'd0, 0);
    step(); idle(32'h80);
    push("rst_prio_pred2", S_PRED, 32'd0, 0);

    // Narrow counters saturate at 3.
    step(); idle(32'h0); reset_small = 1'b1;
    step(); reset_small = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, BEQ, 32'd1, 32'd1, 32'h50, 1'b0, 32'h0);
      if (i == 2) push("small_bcnt_mid", S_SBCNT, 32'd2, 0);
      step();
    end
    idle(32'h0);
    push("small_bcnt_sat", S_SBCNT, 32'd3, 0);
    push("small_mcnt_sat", S_SMCNT, 32'd3, 0);
    step();
    push("small_bcnt_hold", S_SBCNT, 32'd3, 0);

    wait_cycles = 0;
    while (sb_q.size() != 0 && wait_cycles < 10) begin
      step();
      wait_cycles++;
    end
    while (sb_q.size() != 0) begin
      checks++;
      $display("[TB] FAIL %s: never checked, expected 0x%0h", sb_q[0].name, sb_q[0].value);
      void'(sb_q.pop_front());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution and prediction unit for the five-stage pipelined MIPS core. It evaluates branch conditions in EX with signed compares, a wider type set and a valid qualifier. It holds a pattern history table (PHT) of 2-bit saturating counters that IF reads for a taken/not-taken prediction, and updates that table when a branch resolves. It flags mispredictions for the hazard/flush logic and keeps saturating branch and mispredict statistics counters.

## Interface
- DATA_W, 32, operand width of the compared register values
- PC_W, 32, program counter width
- IDX_W, 4, PHT index width; PHT has 2^IDX_W entries
- CNT_W, 16, width of each statistics counter
- clk  input  1  rising-edge clock for all state
- reset  input  1  synchronous, active-high; clears all state at the clock edge where it is sampled high
- if_pc  input  PC_W  PC of the instruction in IF
- if_pred_taken  output  1  prediction for if_pc, combinational from the PHT
- ex_valid  input  1  EX holds a real, non-bubbled instruction
- ex_pc  input  PC_W  PC of the instruction in EX
- ex_branch_type  input  3  condition code, see Operation
- ex_op1, ex_op2  input  DATA_W  operands; datapath drives ex_op2=0 for blez/bgtz/bltz/bgez
- ex_pred_taken  input  1  prediction made for this instruction in IF, piped down
- ex_taken  output  1  resolved condition
- ex_is_branch  output  1  ex_valid and type in 001..110
- ex_mispredict  output  1  ex_is_branch and (ex_taken != ex_pred_taken)
- branch_count  output  CNT_W  resolved branches since reset
- mispredict_count  output  CNT_W  mispredictions since reset

## Operation
- Type encoding: 000 none; 001 beq (op1==op2); 010 bne (op1!=op2); 011 blez (op1<=op2); 100 bgtz (op1>op2); 101 bltz (op1<op2); 110 bgez (op1>=op2); 111 reserved, not a branch.
- All ordered compares are two's-complement signed over DATA_W bits.
- ex_taken is 0 whenever ex_is_branch is 0.
- PHT index is pc[IDX_W+1:2]. Word-aligned PCs; bits [1:0] are ignored.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. if_pred_taken = counter[1] of entry idx(if_pc).
- Update happens on the clock edge when ex_is_branch=1. Entry idx(ex_pc) increments if ex_taken, else decrements, saturating at 11 and 00. No update occurs when ex_is_branch=0, including on type 111 and when ex_valid=0.
- Statistics: branch_count increments on every update edge. mispredict_count increments on every edge with ex_mispredict=1. Both saturate at all-ones and never wrap.
- Reset: every PHT entry is set to 01, both counters to 0. Reset has priority over a simultaneous update.

## Timing
- ex_taken, ex_is_branch and ex_mispredict are combinational from the EX inputs with zero latency, so the hazard unit flushes IF/ID in the same cycle.
- if_pred_taken is a combinational read of the PHT.
- Same-cycle read of an entry being updated returns the pre-update value. The new value is visible from the next cycle (no write-through).
- Statistics outputs are registered and reflect an event one cycle after it.
- Outputs after reset: if_pred_taken=0 for any PC, branch_count=0, mispredict_count=0. Combinational outputs follow their inputs.
- Reset asserted mid-stream: the in-flight EX update is discarded and state equals the post-reset state on the next cycle.
- Aliasing: PCs sharing index bits share one counter. This is intended and needs no tag check.

## Test plan
- Reset, then sweep if_pc over 0x00..0x3C -> if_pred_taken=0 for all; both counts 0.
- Signed compare: bltz with op1=0xFFFFFFFF, op2=0 -> ex_taken=1. bgtz with the same operands -> 0. bgez with op1=0 -> 1. blez with op1=0x7FFFFFFF -> 0.
- Saturation: beq taken at ex_pc=0x40 for 4 cycles -> counter 01→10→11→11. if_pc=0x40 predicts 1 from the cycle after the first update. Then 3 not-taken -> 11→10→01→00, and if_pc=0x40 predicts 0 from the cycle after the second.
- Mispredict: ex_pred_taken=1, bne with op1=op2=5 -> ex_mispredict=1. mispredict_count goes 0→1 next cycle. branch_count goes 0→1.
- Qualifiers: ex_valid=0 with a taken beq, and ex_branch_type=111 with ex_valid=1 -> no PHT change, counts unchanged, ex_taken=0.
- Same-cycle read/write: if_pc=ex_pc=0x80 with entry=01 and a taken branch -> if_pred_taken=0 that cycle, 1 the next. Reset asserted in that same cycle -> entry stays 01. With CNT_W=2, 5 branches -> branch_count holds at 3.
